// File: rtl/pe_dot_sequencer.sv
// pe_dot_sequencer: streams one weighted feature vector into mac_pe and returns its accumulator as a result beat.
// Optional PE_SEQ_LAST_EN adds s_last early termination and a sticky len_err flag.
module pe_dot_sequencer #(
    parameter int DATA_W  = 8,
    parameter int ACC_W   = 32,
    parameter int VEC_LEN = 16,
    parameter int PE_LAT  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [DATA_W-1:0] cfg_weight,
    output logic              cfg_busy,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_feature,
`ifdef PE_SEQ_LAST_EN
    input  logic              s_last,
    output logic              len_err,
`endif
    output logic              pe_clear,
    output logic [DATA_W-1:0] pe_weight,
    output logic [DATA_W-1:0] pe_feature,
    output logic              pe_valid,
    input  logic [ACC_W-1:0]  pe_accum,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [ACC_W-1:0]  m_data
);
    localparam int CW = $clog2(VEC_LEN + 1);
    localparam int DW = $clog2(PE_LAT + 1);

    typedef enum logic [1:0] {CLEAR, STREAM, DRAIN, RESULT} state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [DW-1:0]     dcnt;
    logic [DATA_W-1:0] weight_reg;
    logic              hs;
    logic              full;
    logic              last;

    assign hs   = s_valid && s_ready;
    assign full = cnt == CW'(VEC_LEN - 1);
`ifdef PE_SEQ_LAST_EN
    assign last = full || s_last;
`else
    assign last = full;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= CLEAR;
            s_ready    <= 1'b0;
            pe_valid   <= 1'b0;
            pe_feature <= '0;
            pe_weight  <= '0;
            m_valid    <= 1'b0;
            m_data     <= '0;
            cfg_busy   <= 1'b0;
            cnt        <= '0;
            dcnt       <= '0;
            pe_clear   <= 1'b1;
            weight_reg <= '0;
`ifdef PE_SEQ_LAST_EN
            len_err    <= 1'b0;
`endif
        end else begin
            if (cfg_we && !cfg_busy)
                weight_reg <= cfg_weight;
            pe_valid <= hs;
            if (hs) begin
                pe_feature <= s_feature;
                pe_weight  <= weight_reg;
            end
            case (state)
                CLEAR: begin
                    pe_clear <= 1'b0;
                    s_ready  <= 1'b1;
                    state    <= STREAM;
                end
                STREAM: if (hs) begin
                    cfg_busy <= 1'b1;
                    cnt      <= last ? '0 : cnt + 1'b1;
`ifdef PE_SEQ_LAST_EN
                    if (full && !s_last)
                        len_err <= 1'b1;
`endif
                    if (last) begin
                        s_ready <= 1'b0;
                        dcnt    <= '0;
                        state   <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Final product lands in pe_accum PE_LAT edges after the last pe_valid cycle.
                    if (dcnt == DW'(PE_LAT)) begin
                        m_data   <= pe_accum;
                        m_valid  <= 1'b1;
                        cfg_busy <= 1'b0;
                        state    <= RESULT;
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
                RESULT: if (m_ready) begin
                    m_valid  <= 1'b0;
                    pe_clear <= 1'b1;
                    state    <= CLEAR;
                end
                default: state <= CLEAR;
            endcase
        end
    end
endmodule

// File: tb/tb_pe_dot_sequencer.sv
// tb_pe_dot_sequencer: randomized scenario bench with a behavioural mac_pe and dot-product reference.
module tb_pe_dot_sequencer;
    localparam int VL = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_we = 1'b0;
    logic [7:0]  cfg_weight = '0;
    logic        cfg_busy;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  s_feature = '0;
    logic        s_last = 1'b0;
    logic        pe_clear;
    logic [7:0]  pe_weight;
    logic [7:0]  pe_feature;
    logic        pe_valid;
    logic [31:0] pe_accum;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [31:0] m_data;
`ifdef PE_SEQ_LAST_EN
    logic        len_err;
`endif

    int n_pass = 0;
    int n_chk  = 0;
    int pv_cnt = 0;

    pe_dot_sequencer #(.DATA_W(8), .ACC_W(32), .VEC_LEN(VL), .PE_LAT(1)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_weight(cfg_weight), .cfg_busy(cfg_busy),
        .s_valid(s_valid), .s_ready(s_ready), .s_feature(s_feature),
`ifdef PE_SEQ_LAST_EN
        .s_last(s_last), .len_err(len_err),
`endif
        .pe_clear(pe_clear), .pe_weight(pe_weight), .pe_feature(pe_feature), .pe_valid(pe_valid),
        .pe_accum(pe_accum), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
    );

    always #5 clk = ~clk;

    // Behavioural mac_pe: unsigned acc += w*f, one-cycle latency, cleared by pe_clear.
    always @(posedge clk) begin
        if (pe_clear) pe_accum <= '0;
        else if (pe_valid) pe_accum <= pe_accum + 32'(pe_weight) * 32'(pe_feature);
        if (pe_valid) pv_cnt++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_weight(input logic [7:0] w);
        cfg_we = 1'b1;
        cfg_weight = w;
        tick;
        cfg_we = 1'b0;
    endtask

    task automatic send_beat(input logic [7:0] f, input int bubbles, input logic lst, output bit to);
        int n = 0;
        s_valid = 1'b0;
        repeat (bubbles) tick;
        s_valid = 1'b1;
        s_feature = f;
        s_last = lst;
        while (!s_ready && n < 50) begin tick; n++; end
        to = !s_ready;
        if (!to) tick;
        s_valid = 1'b0;
        s_last = 1'b0;
    endtask

    task automatic send_vec(input logic [VL-1:0][7:0] f, input int bub, output int tos);
        bit t;
        tos = 0;
        for (int i = 0; i < VL; i++) begin
            send_beat(f[i], bub < 0 ? int'($urandom_range(0, 2)) : bub, 1'b0, t);
            tos += int'(t);
        end
    endtask

    task automatic get_result(input int hold, output logic [31:0] d, output bit to,
                              output bit stable, output bit sr_seen, output logic mv_after);
        int n = 0;
        sr_seen = 1'b0;
        stable = 1'b1;
        while (!m_valid && n < 100) begin sr_seen |= s_ready; tick; n++; end
        to = !m_valid;
        d = m_data;
        repeat (hold) begin
            tick;
            stable &= (m_valid === 1'b1 && m_data === d);
            sr_seen |= s_ready;
        end
        m_ready = 1'b1;
        tick;
        mv_after = m_valid;
        m_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        n_chk++;
        if ({s_ready, pe_valid, m_valid, cfg_busy, pe_clear} !== 5'b00001)
            $display("FAIL reset_ctrl got %b want 00001", {s_ready, pe_valid, m_valid, cfg_busy, pe_clear});
        else n_pass++;
        n_chk++;
        if ({m_data, pe_weight, pe_feature} !== 48'd0)
            $display("FAIL reset_data got %h want 0", {m_data, pe_weight, pe_feature});
        else n_pass++;
        rst = 1'b0;
        tick;
        n_chk++;
        if ({s_ready, pe_clear, cfg_busy} !== 3'b100)
            $display("FAIL reset_release got %b want 100", {s_ready, pe_clear, cfg_busy});
        else n_pass++;
    endtask

    task automatic test_basic;
        logic [31:0] d; bit to, st, sr; logic mva; int tos, p0;
        set_weight(8'd3);
        m_ready = 1'b1;
        p0 = pv_cnt;
        send_vec({8'd4, 8'd3, 8'd2, 8'd1}, 0, tos);
        get_result(0, d, to, st, sr, mva);
        n_chk++;
        if (to || tos != 0 || d !== 32'd30) $display("FAIL basic_data got %0d (to=%0d) want 30", d, to);
        else n_pass++;
        n_chk++;
        if (pv_cnt - p0 != 4) $display("FAIL basic_pe_valid got %0d pulses want 4", pv_cnt - p0);
        else n_pass++;
        n_chk++;
        if (mva !== 1'b0) $display("FAIL basic_pulse m_valid after accept got %b want 0", mva);
        else n_pass++;
        n_chk++;
        if (pe_weight !== 8'd3) $display("FAIL basic_pe_weight got %0d want 3", pe_weight);
        else n_pass++;
    endtask

    task automatic test_stall;
        logic [31:0] d; bit to, st, sr; logic mva; int tos;
        set_weight(8'd255);
        send_vec({4{8'd255}}, 1, tos);
        get_result(5, d, to, st, sr, mva);
        n_chk++;
        if (to || tos != 0 || d !== 32'd260100) $display("FAIL stall_data got %0d want 260100", d);
        else n_pass++;
        n_chk++;
        if (!st) $display("FAIL stall_stable got unstable want held");
        else n_pass++;
        n_chk++;
        if (sr) $display("FAIL stall_s_ready got 1 want 0");
        else n_pass++;
    endtask

    task automatic test_cfg_busy;
        logic [31:0] d; bit to, st, sr, t; logic mva; int tos;
        set_weight(8'd2);
        send_beat(8'd1, 0, 1'b0, t);
        send_beat(8'd1, 0, 1'b0, t);
        cfg_we = 1'b1;
        cfg_weight = 8'd7;
        n_chk++;
        if (cfg_busy !== 1'b1) $display("FAIL cfg_busy_mid got %b want 1", cfg_busy);
        else n_pass++;
        send_beat(8'd1, 0, 1'b0, t);
        send_beat(8'd1, 0, 1'b0, t);
        get_result(0, d, to, st, sr, mva);
        cfg_we = 1'b0;
        n_chk++;
        if (to || d !== 32'd8) $display("FAIL cfg_ignored got %0d want 8", d);
        else n_pass++;
        send_vec({4{8'd1}}, 0, tos);
        get_result(0, d, to, st, sr, mva);
        n_chk++;
        if (to || d !== 32'd28) $display("FAIL cfg_applied got %0d want 28", d);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [VL-1:0][7:0] f1, f2;
        logic [7:0] w;
        int s1 = 0, s2 = 0, tos, n;
        bit pc;
        logic [31:0] d1, d2;
        w = 8'($urandom_range(1, 255));
        for (int i = 0; i < VL; i++) begin
            f1[i] = 8'($urandom); f2[i] = 8'($urandom);
            s1 += int'(f1[i]); s2 += int'(f2[i]);
        end
        set_weight(w);
        m_ready = 1'b1;
        send_vec(f1, 0, tos);
        n = 0;
        while (!m_valid && n < 20) begin tick; n++; end
        d1 = m_data;
        n = 0; pc = 1'b0;
        while (!s_ready && n < 10) begin tick; n++; pc |= pe_clear; end
        n_chk++;
        if (d1 !== 32'(int'(w) * s1)) $display("FAIL b2b_first got %0d want %0d", d1, int'(w) * s1);
        else n_pass++;
        n_chk++;
        if (n != 2) $display("FAIL b2b_gap got %0d cycles want 2", n);
        else n_pass++;
        n_chk++;
        if (!pc) $display("FAIL b2b_clear got no pe_clear want pulse");
        else n_pass++;
        send_vec(f2, 0, tos);
        n = 0;
        while (!m_valid && n < 20) begin tick; n++; end
        d2 = m_data;
        tick;
        m_ready = 1'b0;
        n_chk++;
        if (d2 !== 32'(int'(w) * s2)) $display("FAIL b2b_second got %0d want %0d", d2, int'(w) * s2);
        else n_pass++;
    endtask

    task automatic test_reset_abort;
        logic [31:0] d; bit to, st, sr, t, seen; logic mva; int tos;
        set_weight(8'd5);
        send_beat(8'd9, 0, 1'b0, t);
        send_beat(8'd9, 0, 1'b0, t);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        n_chk++;
        if ({m_valid, cfg_busy, m_data} !== 34'd0)
            $display("FAIL abort_state got mv=%b busy=%b data=%0d want 0", m_valid, cfg_busy, m_data);
        else n_pass++;
        seen = 1'b0;
        repeat (10) begin tick; seen |= m_valid; end
        n_chk++;
        if (seen) $display("FAIL abort_no_result got m_valid=1 want 0");
        else n_pass++;
        set_weight(8'd1);
        send_vec({4{8'd2}}, 0, tos);
        get_result(1, d, to, st, sr, mva);
        n_chk++;
        if (to || d !== 32'd8) $display("FAIL abort_next got %0d want 8", d);
        else n_pass++;
    endtask

    task automatic test_random;
        logic [31:0] d; bit to, st, sr, t; logic mva;
        logic [7:0] w, f;
        int s;
        for (int k = 0; k < 12; k++) begin
            w = 8'($urandom);
            set_weight(w);
            s = 0;
            for (int i = 0; i < VL; i++) begin
                f = 8'($urandom);
                s += int'(f);
                send_beat(f, int'($urandom_range(0, 2)), 1'b0, t);
                cfg_we = (i < VL - 1) ? 1'($urandom) : 1'b0;
                cfg_weight = 8'($urandom);
            end
            get_result(int'($urandom_range(0, 3)), d, to, st, sr, mva);
            n_chk++;
            if (to || !st || mva !== 1'b0 || d !== 32'(int'(w) * s))
                $display("FAIL random_%0d got %0d (to=%0d st=%0d) want %0d", k, d, to, st, int'(w) * s);
            else n_pass++;
        end
    endtask

`ifdef PE_SEQ_LAST_EN
    task automatic test_last;
        logic [31:0] d; bit to, st, sr, t; logic mva; int tos;
        set_weight(8'd2);
        send_beat(8'd5, 0, 1'b0, t);
        send_beat(8'd5, 0, 1'b1, t);
        get_result(0, d, to, st, sr, mva);
        n_chk++;
        if (to || d !== 32'd20 || len_err !== 1'b0)
            $display("FAIL last_early got %0d err=%b want 20 err=0", d, len_err);
        else n_pass++;
        send_vec({4{8'd1}}, 0, tos);
        get_result(0, d, to, st, sr, mva);
        n_chk++;
        if (to || d !== 32'd8 || len_err !== 1'b1)
            $display("FAIL last_len_err got %0d err=%b want 8 err=1", d, len_err);
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset;
        test_basic;
        test_stall;
        test_cfg_busy;
        test_back_to_back;
        test_reset_abort;
        test_random;
`ifdef PE_SEQ_LAST_EN
        test_last;
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
